// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between NREQ writeback sources.
// Optional SP_PROTECT_EN: only requester NREQ-1 may write register 2^AW-1.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 8,
  parameter int AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic                 sp_viol
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] winner;
  logic          found;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          xfer;
  logic          wr_en;

  // Cyclic scan starting one past the last winner; the first valid requester wins.
  always_comb begin : grant_scan
    int idx;
    // NOTE: every output of this block gets a default first so no latch is inferred.
    found    = 1'b0;
    winner   = '0;
    sel_addr = '0;
    sel_data = '0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        winner   = PW'(idx);
        sel_addr = req_addr[idx*AW +: AW];
        sel_data = req_data[idx*DW +: DW];
      end
    end
  end

  assign xfer      = found & ~stall & ~rst;
  assign req_ready = xfer ? (NREQ'(1) << winner) : '0;

`ifdef SP_PROTECT_EN
  logic sp_hit;

  // A non-owner targeting the stack pointer is still accepted but its write is dropped.
  assign sp_hit = xfer && (sel_addr == '1) && (winner != PW'(NREQ - 1));
  assign wr_en  = xfer & ~sp_hit;

  always_ff @(posedge clk) begin
    if (rst) sp_viol <= 1'b0;
    else if (sp_hit) sp_viol <= 1'b1;
  end
`else
  assign wr_en   = xfer;
  assign sp_viol = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rr_ptr   <= PW'(NREQ - 1);
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
      if (xfer) rr_ptr <= winner;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter; define SP_PROTECT_EN to exercise protection.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 8;
  localparam int AW   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 stall;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [DW-1:0]        rf_wdata;
  logic                 sp_viol;

  int vectors    = 0;
  int miscompares = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .sp_viol   (sp_viol)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    stall     = 1'b0;
    req_valid = 3'b111;
    req_addr  = '1;
    req_data  = '1;
    tick();
    tick();
    #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", rf_we); end
    vectors++; if (rf_waddr !== 2'd0) begin miscompares++; $display("FAIL reset_waddr: got %h want 0", rf_waddr); end
    vectors++; if (rf_wdata !== 8'h00) begin miscompares++; $display("FAIL reset_wdata: got %h want 00", rf_wdata); end
    vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    vectors++; if (sp_viol !== 1'b0) begin miscompares++; $display("FAIL reset_sp_viol: got %b want 0", sp_viol); end
    req_valid = '0;
    rst       = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_req(1, 2'd2, 8'h5A);
    req_valid = 3'b010;
    #1;
    vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL single_ready: got %b want 010", req_ready); end
    tick();
    req_valid = '0;
    vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL single_we: got %b want 1", rf_we); end
    vectors++; if (rf_waddr !== 2'd2) begin miscompares++; $display("FAIL single_waddr: got %h want 2", rf_waddr); end
    vectors++; if (rf_wdata !== 8'h5A) begin miscompares++; $display("FAIL single_wdata: got %h want 5a", rf_wdata); end
    tick();
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL single_we_after: got %b want 0", rf_we); end
    vectors++; if (rf_waddr !== 2'd2 || rf_wdata !== 8'h5A) begin
      miscompares++; $display("FAIL single_hold: got %h/%h want 2/5a", rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_ready [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [AW-1:0]   exp_addr  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [DW-1:0]   exp_data  [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hA0};
    set_req(0, 2'd0, 8'hA0);
    set_req(1, 2'd1, 8'hB1);
    set_req(2, 2'd2, 8'hC2);
    req_valid = 3'b111;
    rst = 1'b1;
    tick();
    #1;
    vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL rr_ready_in_rst: got %b want 000", req_ready); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (req_ready !== exp_ready[i]) begin
        miscompares++; $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, exp_ready[i]);
      end
      tick();
      vectors++; if (rf_we !== 1'b1 || rf_waddr !== exp_addr[i] || rf_wdata !== exp_data[i]) begin
        miscompares++;
        $display("FAIL rr_write[%0d]: got we=%b %h/%h want we=1 %h/%h", i, rf_we, rf_waddr, rf_wdata, exp_addr[i], exp_data[i]);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    set_req(0, 2'd1, 8'h33);
    req_valid = 3'b001;
    stall     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL stall_ready[%0d]: got %b want 000", i, req_ready); end
      tick();
      vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL stall_we[%0d]: got %b want 0", i, rf_we); end
    end
    stall = 1'b0;
    #1;
    vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL stall_release_ready: got %b want 001", req_ready); end
    tick();
    req_valid = '0;
    vectors++; if (rf_we !== 1'b1 || rf_waddr !== 2'd1 || rf_wdata !== 8'h33) begin
      miscompares++; $display("FAIL stall_release_write: got we=%b %h/%h want we=1 1/33", rf_we, rf_waddr, rf_wdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    set_req(1, 2'd3, 8'h77);
    req_valid = 3'b010;
    #1;
    vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL midrst_ready: got %b want 010", req_ready); end
    tick();
    req_valid = '0;
    rst       = 1'b1;
    #1;
    vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL midrst_we_n1: got %b want 1", rf_we); end
    tick();
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL midrst_we_n2: got %b want 0", rf_we); end
    rst = 1'b0;
    set_req(0, 2'd0, 8'h10);
    req_valid = 3'b111;
    #1;
    vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL midrst_priority: got %b want 001", req_ready); end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_same_addr();
    apply_reset();
    set_req(0, 2'd1, 8'h11);
    set_req(2, 2'd1, 8'h22);
    req_valid = 3'b101;
    #1;
    vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL same_ready0: got %b want 001", req_ready); end
    tick();
    req_valid = 3'b100;
    vectors++; if (rf_we !== 1'b1 || rf_waddr !== 2'd1 || rf_wdata !== 8'h11) begin
      miscompares++; $display("FAIL same_write0: got we=%b %h/%h want we=1 1/11", rf_we, rf_waddr, rf_wdata);
    end
    #1;
    vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL same_ready2: got %b want 100", req_ready); end
    tick();
    req_valid = '0;
    vectors++; if (rf_we !== 1'b1 || rf_waddr !== 2'd1 || rf_wdata !== 8'h22) begin
      miscompares++; $display("FAIL same_write2: got we=%b %h/%h want we=1 1/22", rf_we, rf_waddr, rf_wdata);
    end
    tick();
  endtask

`ifdef SP_PROTECT_EN
  task automatic test_sp_protect();
    apply_reset();
    set_req(0, 2'd3, 8'hFF);
    req_valid = 3'b001;
    #1;
    vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL sp_ready0: got %b want 001", req_ready); end
    tick();
    req_valid = '0;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL sp_suppress: got %b want 0", rf_we); end
    vectors++; if (sp_viol !== 1'b1) begin miscompares++; $display("FAIL sp_viol_set: got %b want 1", sp_viol); end
    tick();
    vectors++; if (sp_viol !== 1'b1) begin miscompares++; $display("FAIL sp_viol_sticky: got %b want 1", sp_viol); end
    set_req(2, 2'd3, 8'hFE);
    req_valid = 3'b100;
    #1;
    vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL sp_ready2: got %b want 100", req_ready); end
    tick();
    req_valid = '0;
    vectors++; if (rf_we !== 1'b1 || rf_waddr !== 2'd3 || rf_wdata !== 8'hFE) begin
      miscompares++; $display("FAIL sp_owner_write: got we=%b %h/%h want we=1 3/fe", rf_we, rf_waddr, rf_wdata);
    end
    vectors++; if (sp_viol !== 1'b1) begin miscompares++; $display("FAIL sp_viol_hold: got %b want 1", sp_viol); end
    apply_reset();
    #1;
    vectors++; if (sp_viol !== 1'b0) begin miscompares++; $display("FAIL sp_viol_clear: got %b want 0", sp_viol); end
  endtask
`else
  task automatic test_sp_open();
    apply_reset();
    set_req(0, 2'd3, 8'hFF);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    vectors++; if (rf_we !== 1'b1 || rf_waddr !== 2'd3 || rf_wdata !== 8'hFF) begin
      miscompares++; $display("FAIL sp_open_write: got we=%b %h/%h want we=1 3/ff", rf_we, rf_waddr, rf_wdata);
    end
    vectors++; if (sp_viol !== 1'b0) begin miscompares++; $display("FAIL sp_open_viol: got %b want 0", sp_viol); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_mid_op();
    test_same_addr();
`ifdef SP_PROTECT_EN
    test_sp_protect();
`else
    test_sp_open();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
